// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI-facing register bank.
// SPI_REG_ID_EN (see spi_reg_bank / spi_reg_mem) makes address 0 a read-only ID register.
package spi_reg_pkg;

  localparam int ADDRSZ_DEF  = 7;
  localparam int PAYLOAD_DEF = 8;
  localparam logic [7:0] ID_VAL_DEF = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    RD_HOLD,
    WR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_reg_mem.sv
// Register array: one SPI write port merged with a local write port (SPI wins on address clash),
// a combinational SPI read port and a registered local read port. SPI_REG_ID_EN pins address 0.
module spi_reg_mem
  import spi_reg_pkg::*;
#(
  parameter int                 ADDRSZ  = ADDRSZ_DEF,
  parameter int                 PAYLOAD = PAYLOAD_DEF,
  parameter logic [PAYLOAD-1:0] RST_VAL = '0,
  parameter logic [PAYLOAD-1:0] ID_VAL  = PAYLOAD'(ID_VAL_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spi_we,
  input  logic [ADDRSZ-1:0]  spi_waddr,
  input  logic [PAYLOAD-1:0] spi_wdata,
  input  logic [ADDRSZ-1:0]  spi_raddr,
  output logic [PAYLOAD-1:0] spi_rdata,
  input  logic               loc_we,
  input  logic [ADDRSZ-1:0]  loc_addr,
  input  logic [PAYLOAD-1:0] loc_wdata,
  output logic [PAYLOAD-1:0] loc_rdata,
  output logic               collision
);

  localparam int DEPTH = 2 ** ADDRSZ;

  logic [PAYLOAD-1:0] mem [DEPTH];
  logic               loc_ok;
  logic               clash;
  logic               loc_we_eff;
  logic [PAYLOAD-1:0] loc_rd_val;

`ifdef SPI_REG_ID_EN
  assign loc_ok     = (loc_addr != '0);
  assign spi_rdata  = (spi_raddr == '0) ? ID_VAL : mem[spi_raddr];
  assign loc_rd_val = (loc_addr == '0) ? ID_VAL : mem[loc_addr];
`else
  assign loc_ok     = 1'b1;
  assign spi_rdata  = mem[spi_raddr];
  assign loc_rd_val = mem[loc_addr];
`endif

  assign clash      = spi_we & loc_we & loc_ok & (spi_waddr == loc_addr);
  assign loc_we_eff = loc_we & loc_ok & ~clash;

  // Reads sample the pre-write contents, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      loc_rdata <= '0;
      collision <= 1'b0;
    end else begin
      if (spi_we)     mem[spi_waddr] <= spi_wdata;
      if (loc_we_eff) mem[loc_addr]  <= loc_wdata;
      loc_rdata <= loc_rd_val;
      collision <= clash;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: frame FSM, edge detection and output registers around spi_reg_mem.
// Define SPI_REG_ID_EN to make address 0 a read-only ID register returning ID_VAL.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                 ADDRSZ  = ADDRSZ_DEF,
  parameter int                 PAYLOAD = PAYLOAD_DEF,
  parameter logic [PAYLOAD-1:0] RST_VAL = '0,
  parameter logic [PAYLOAD-1:0] ID_VAL  = PAYLOAD'(ID_VAL_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDRSZ-1:0]  addr,
  input  logic               addr_dv,
  input  logic [PAYLOAD-1:0] rx_d,
  input  logic               rxdv,
  input  logic               rw_out,
  output logic [PAYLOAD-1:0] tx_d,
  output logic               tx_en,
  input  logic [ADDRSZ-1:0]  loc_addr,
  input  logic               loc_we,
  input  logic [PAYLOAD-1:0] loc_wdata,
  output logic [PAYLOAD-1:0] loc_rdata,
  output logic               wr_strobe,
  output logic [ADDRSZ-1:0]  wr_addr,
  output logic               loc_collision
);

  state_t             state, state_nxt;
  logic               addr_dv_q, rxdv_q;
  logic               adv_re, adv_fe, rxdv_re;
  logic [ADDRSZ-1:0]  addr_hold;
  logic               capture, rd_load, rd_clear, spi_commit, addr_ok;
  logic [PAYLOAD-1:0] spi_rdata;

  assign adv_re  = addr_dv & ~addr_dv_q;
  assign adv_fe  = ~addr_dv & addr_dv_q;
  assign rxdv_re = rxdv & ~rxdv_q;

`ifdef SPI_REG_ID_EN
  assign addr_ok = (addr_hold != '0);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    rd_load    = 1'b0;
    rd_clear   = 1'b0;
    spi_commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (adv_re) begin
          capture = 1'b1;
          if (rw_out) begin
            rd_load   = 1'b1;
            state_nxt = RD_HOLD;
          end else begin
            state_nxt = WR_WAIT;
          end
        end
      end
      RD_HOLD: begin
        if (adv_fe) begin
          rd_clear  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        // A payload landing on the frame's last cycle still commits, then returns straight to IDLE.
        if (rxdv_re) begin
          spi_commit = addr_ok;
          state_nxt  = adv_fe ? IDLE : DONE;
        end else if (adv_fe) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (adv_fe) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_dv_q <= 1'b0;
      rxdv_q    <= 1'b0;
      addr_hold <= '0;
      tx_d      <= '0;
      tx_en     <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state     <= state_nxt;
      addr_dv_q <= addr_dv;
      rxdv_q    <= rxdv;
      if (capture) addr_hold <= addr;
      if (rd_load) begin
        tx_d  <= spi_rdata;
        tx_en <= 1'b1;
      end else if (rd_clear) begin
        tx_d  <= '0;
        tx_en <= 1'b0;
      end
      wr_strobe <= spi_commit;
      if (spi_commit) wr_addr <= addr_hold;
    end
  end

  // SPI reads use the live address because the lookup happens on the same cycle it is captured.
  spi_reg_mem #(
    .ADDRSZ  (ADDRSZ),
    .PAYLOAD (PAYLOAD),
    .RST_VAL (RST_VAL),
    .ID_VAL  (ID_VAL)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .spi_we    (spi_commit),
    .spi_waddr (addr_hold),
    .spi_wdata (rx_d),
    .spi_raddr (addr),
    .spi_rdata (spi_rdata),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .collision (loc_collision)
  );

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus queues expected responses, a negedge monitor checks them.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] addr = '0;
  logic       addr_dv = 1'b0;
  logic [7:0] rx_d = '0;
  logic       rxdv = 1'b0;
  logic       rw_out = 1'b0;
  logic [7:0] tx_d;
  logic       tx_en;
  logic [6:0] loc_addr = '0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_wdata = '0;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic       loc_collision;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .addr_dv       (addr_dv),
    .rx_d          (rx_d),
    .rxdv          (rxdv),
    .rw_out        (rw_out),
    .tx_d          (tx_d),
    .tx_en         (tx_en),
    .loc_addr      (loc_addr),
    .loc_we        (loc_we),
    .loc_wdata     (loc_wdata),
    .loc_rdata     (loc_rdata),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .loc_collision (loc_collision)
  );

  typedef struct packed {
    logic [6:0] a;
    logic       coll;
  } wr_exp_t;

`ifdef SPI_REG_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  wr_exp_t    wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic       rd_req = 1'b0;
  logic       rd_vld_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with no expected entry queued", nm);
  endtask

  always @(posedge clk) rd_vld_q <= rd_req;

  int         negcnt = 0;
  int         adv_rise_n = 0;
  logic       prev_txen = 1'b0;
  logic       prev_adv = 1'b0;
  logic [7:0] cur_tx = '0;
  wr_exp_t    we_e;

  always @(negedge clk) begin
    negcnt++;
    if (addr_dv && !prev_adv) adv_rise_n = negcnt;
    if (rd_vld_q) begin
      if (rd_q.size() == 0) fail("loc_rdata");
      else chk("loc_rdata", loc_rdata, rd_q.pop_front());
    end
    if (wr_strobe) begin
      if (wr_q.size() == 0) fail("wr_strobe");
      else begin
        we_e = wr_q.pop_front();
        chk("wr_addr", wr_addr, we_e.a);
        chk("loc_collision", loc_collision, we_e.coll);
      end
    end else if (loc_collision) begin
      fail("loc_collision");
    end
    if (tx_en && !prev_txen) begin
      if (tx_q.size() == 0) fail("tx_en");
      else begin
        cur_tx = tx_q.pop_front();
        chk("tx_en latency", negcnt - adv_rise_n, 1);
        chk("tx_d", tx_d, cur_tx);
      end
    end else if (tx_en) begin
      chk("tx_d hold", tx_d, cur_tx);
    end else if (prev_txen) begin
      chk("tx_d after frame", tx_d, 0);
      chk("tx_en after frame", addr_dv, 0);
    end
    prev_txen = tx_en;
    prev_adv  = addr_dv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loc_rd(input logic [6:0] a, input logic [7:0] e);
    loc_addr = a;
    rd_req   = 1'b1;
    rd_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic loc_wr(input logic [6:0] a, input logic [7:0] d);
    loc_addr  = a;
    loc_wdata = d;
    loc_we    = 1'b1;
    tick();
    loc_we = 1'b0;
  endtask

  task automatic spi_wr(input logic [6:0] a, input logic [7:0] d, input bit commit,
                        input bit with_loc, input logic [6:0] la, input logic [7:0] ld,
                        input bit coll);
    wr_exp_t e;
    addr    = a;
    rw_out  = 1'b0;
    addr_dv = 1'b1;
    tick();
    tick();
    rx_d = d;
    rxdv = 1'b1;
    if (with_loc) begin
      loc_addr  = la;
      loc_wdata = ld;
      loc_we    = 1'b1;
    end
    if (commit) begin
      e.a    = a;
      e.coll = coll;
      wr_q.push_back(e);
    end
    tick();
    loc_we = 1'b0;
    tick();
    addr_dv = 1'b0;
    rxdv    = 1'b0;
    tick();
    tick();
  endtask

  task automatic spi_rd(input logic [6:0] a, input logic [7:0] e);
    tx_q.push_back(e);
    addr    = a;
    rw_out  = 1'b1;
    addr_dv = 1'b1;
    tick();
    tick();
    addr = a ^ 7'h12;
    tick();
    tick();
    addr_dv = 1'b0;
    tick();
    tick();
    rw_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst tx_d", tx_d, 0);
    chk("rst tx_en", tx_en, 0);
    chk("rst loc_rdata", loc_rdata, 0);
    chk("rst wr_strobe", wr_strobe, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst loc_collision", loc_collision, 0);
    reset = 1'b0;
    for (int i = 0; i < 128; i++) loc_rd(7'(i), (ID_EN && i == 0) ? 8'hA5 : 8'h00);

    // basic SPI write then local readback
    spi_wr(7'h12, 8'h3C, 1'b1, 1'b0, '0, '0, 1'b0);
    loc_rd(7'h12, 8'h3C);

    // local write then SPI read
    loc_wr(7'h40, 8'h99);
    spi_rd(7'h40, 8'h99);

    // same-cycle SPI commit and local write
    spi_wr(7'h05, 8'h5A, 1'b1, 1'b1, 7'h05, 8'hC3, 1'b1);
    loc_rd(7'h05, 8'h5A);
    spi_wr(7'h05, 8'h6B, 1'b1, 1'b1, 7'h06, 8'h77, 1'b0);
    loc_rd(7'h05, 8'h6B);
    loc_rd(7'h06, 8'h77);

    // read-before-write on the local port
    loc_addr  = 7'h12;
    loc_wdata = 8'hE1;
    loc_we    = 1'b1;
    rd_req    = 1'b1;
    rd_q.push_back(8'h3C);
    tick();
    loc_we = 1'b0;
    rd_req = 1'b0;
    loc_rd(7'h12, 8'hE1);

    // aborted write frame: addr_dv pulse with no payload
    addr    = 7'h12;
    rw_out  = 1'b0;
    addr_dv = 1'b1;
    repeat (3) tick();
    addr_dv = 1'b0;
    repeat (2) tick();
    loc_rd(7'h12, 8'hE1);

    // two payload edges in one frame: only the first commits
    addr    = 7'h50;
    addr_dv = 1'b1;
    tick();
    rx_d = 8'h01;
    rxdv = 1'b1;
    we_push(7'h50);
    tick();
    rxdv = 1'b0;
    tick();
    rx_d = 8'h02;
    rxdv = 1'b1;
    tick();
    tick();
    addr_dv = 1'b0;
    rxdv    = 1'b0;
    tick();
    tick();
    loc_rd(7'h50, 8'h01);

    // reset while waiting for the payload
    addr    = 7'h30;
    addr_dv = 1'b1;
    tick();
    tick();
    rx_d  = 8'h77;
    rxdv  = 1'b1;
    reset = 1'b1;
    tick();
    addr_dv = 1'b0;
    rxdv    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    loc_rd(7'h30, 8'h00);
    loc_rd(7'h12, 8'h00);
    spi_wr(7'h31, 8'h42, 1'b1, 1'b0, '0, '0, 1'b0);
    loc_rd(7'h31, 8'h42);
    spi_rd(7'h31, 8'h42);

    // address 0: ordinary register, or read-only ID
    spi_wr(7'h00, 8'h11, !ID_EN, 1'b0, '0, '0, 1'b0);
    spi_rd(7'h00, ID_EN ? 8'hA5 : 8'h11);
    loc_wr(7'h00, 8'h22);
    loc_rd(7'h00, ID_EN ? 8'hA5 : 8'h22);

    repeat (5) tick();
    chk("wr_q drained", wr_q.size(), 0);
    chk("tx_q drained", tx_q.size(), 0);
    chk("rd_q drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic we_push(input logic [6:0] a);
    wr_exp_t e;
    e.a    = a;
    e.coll = 1'b0;
    wr_q.push_back(e);
  endtask

endmodule
